// File: rtl/axis_descaler.sv
// Purpose: recovers x = ((y - offset) * 2^15) / scale on an AXI-Stream sample using a sign-magnitude restoring divider.
// Latency: W+17 cycles from input handshake to m_axis_tvalid (W+18 with AXIS_DESCALER_ROUND_EN); 1 cycle when scale is zero.
// Backpressure: one sample in flight; s_axis_tready low until the held output is taken. Optional macro: AXIS_DESCALER_ROUND_EN.
module axis_descaler #(
  parameter int AXIS_TDATA_WIDTH = 14
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [31:0]                 cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int DW = W + 16;              // dividend / quotient width
  localparam int CW = $clog2(DW + 1);      // step counter width
  localparam logic [CW-1:0] STEPS = CW'(DW);

  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] quo_q;    // holds dividend, shifts out MSB first, quotient shifts in
  logic [16:0]   rem_q;
  logic [15:0]   dvs_q;
  logic          neg_q;
  logic          zero_q;
`ifdef AXIS_DESCALER_ROUND_EN
  logic          rnd_pend_q;
`endif

  // Input-side arithmetic, only meaningful at the IDLE handshake
  logic signed [W-1:0] off_w;
  logic signed [W:0]   diff_w;
  logic [W:0]          diff_mag;
  logic [15:0]         scl;
  logic [15:0]         scl_mag;

  assign off_w    = cfg_data[W+15:16];
  assign scl      = cfg_data[15:0];
  assign diff_w   = {s_axis_tdata[W-1], s_axis_tdata} - {off_w[W-1], off_w};
  assign diff_mag = diff_w[W] ? (~diff_w + (W+1)'(1)) : diff_w;
  // -32768 maps to 16'h8000, which is the correct unsigned magnitude
  assign scl_mag  = scl[15] ? (~scl + 16'd1) : scl;

  // Single restoring step: shift in next dividend bit, subtract if it fits
  logic [16:0] rem_sh;
  logic [16:0] rem_sub;
  logic        step_fit;

  assign rem_sh   = {rem_q[15:0], quo_q[DW-1]};
  assign rem_sub  = rem_sh - {1'b0, dvs_q};
  assign step_fit = (rem_sh >= {1'b0, dvs_q});

  // Result formation: apply sign to the truncated magnitude, then saturate
  logic [DW-1:0] neg_mag;
  logic [W-1:0]  res_dat;
  logic          res_sat;

  always_comb begin
    res_dat = '0;
    res_sat = 1'b0;
    neg_mag = ~quo_q + DW'(1);
    if (zero_q) begin
      res_sat = 1'b1;
      if (quo_q == '0)
        res_dat = '0;
      else if (neg_q)
        res_dat = MIN_V;
      else
        res_dat = MAX_V;
    end else if (!neg_q) begin
      if (quo_q > {{16{1'b0}}, MAX_V}) begin
        res_dat = MAX_V;
        res_sat = 1'b1;
      end else begin
        res_dat = quo_q[W-1:0];
      end
    end else begin
      // magnitude exactly 2^(W-1) is representable as the most negative value
      if (quo_q > {{16{1'b0}}, MIN_V}) begin
        res_dat = MIN_V;
        res_sat = 1'b1;
      end else begin
        res_dat = neg_mag[W-1:0];
      end
    end
  end

  // Bits that carry no information in this configuration
  logic spare_unused;
  assign spare_unused = ^{cfg_data[31:W+16], rem_q[16], neg_mag[DW-1:W]};

  assign s_axis_tready = (state_q == IDLE);

  // Control FSM, divider datapath and registered output stage
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      neg_q         <= 1'b0;
      zero_q        <= 1'b0;
`ifdef AXIS_DESCALER_ROUND_EN
      rnd_pend_q    <= 1'b0;
`endif
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_axis_tvalid) begin
            quo_q   <= {diff_mag, 15'd0};
            rem_q   <= '0;
            dvs_q   <= scl_mag;
            neg_q   <= diff_w[W] ^ scl[15];
            zero_q  <= (scl == 16'd0);
            // zero scale skips every divide step and goes to OUTPUT next edge
            cnt_q   <= (scl == 16'd0) ? '0 : STEPS;
`ifdef AXIS_DESCALER_ROUND_EN
            rnd_pend_q <= (scl != 16'd0);
`endif
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (cnt_q != '0) begin
            rem_q <= step_fit ? rem_sub : rem_sh;
            quo_q <= {quo_q[DW-2:0], step_fit};
            cnt_q <= cnt_q - CW'(1);
`ifdef AXIS_DESCALER_ROUND_EN
          end else if (rnd_pend_q) begin
            // round half away from zero on the magnitude
            rnd_pend_q <= 1'b0;
            if ({rem_q, 1'b0} >= {2'b00, dvs_q})
              quo_q <= quo_q + DW'(1);
`endif
          end else begin
            m_axis_tdata  <= res_dat;
            m_axis_tuser  <= res_sat;
            m_axis_tvalid <= 1'b1;
            state_q       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_descaler.sv
// Bench for axis_descaler (W=14): directed vectors, expected results queued at issue,
// popped and compared by a monitor at each output handshake.
module tb_axis_descaler;

`ifdef AXIS_DESCALER_ROUND_EN
  localparam int LAT = 32;
  localparam logic signed [13:0] R5 = 14'sd7;
`else
  localparam int LAT = 31;
  localparam logic signed [13:0] R5 = 14'sd6;
`endif

  logic        aclk;
  logic        areset;
  logic [31:0] cfg_data;
  logic [13:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [13:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  axis_descaler #(.AXIS_TDATA_WIDTH(14)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic signed [13:0] dat;
    logic               usr;
    int                 lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cyc = 0;
  int   lat_obs = 0;
  logic vld_d = 1'b0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Runs at each negedge: tracks accept/rise cycles and scores output handshakes
  task automatic monitor_step();
    exp_t e;
    if (areset) begin
      vld_d = 1'b0;
      return;
    end
    if (s_axis_tvalid && s_axis_tready) acc_cyc = cyc + 1;
    if (m_axis_tvalid && !vld_d) lat_obs = cyc - acc_cyc;
    vld_d = m_axis_tvalid;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got tdata=%0d tuser=%0b, expected no output", $signed(m_axis_tdata), m_axis_tuser);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", $signed(m_axis_tdata), e.dat);
        chk("tuser", {31'd0, m_axis_tuser}, {31'd0, e.usr});
        if (e.lat >= 0) chk("latency", lat_obs, e.lat);
      end
    end
  endtask

  // Present one sample and hold it until accepted; optionally queue its expectation
  task automatic send(input logic signed [13:0] y, input logic [15:0] scl, input logic signed [13:0] off,
                      input logic signed [13:0] ed, input logic eu, input int el,
                      input bit push, input bit scramble);
    int t;
    exp_t e;
    cfg_data      = {2'b00, off, scl};
    s_axis_tdata  = y;
    s_axis_tvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_axis_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!s_axis_tready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: s_axis_tready=0, expected 1 within 200 cycles");
    end
    if (push) begin
      e.dat = ed;
      e.usr = eu;
      e.lat = el;
      exp_q.push_back(e);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    if (scramble) begin
      repeat (5) @(posedge aclk);
      #1;
      cfg_data = 32'h0064_0001;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge aclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic run(input logic signed [13:0] y, input logic [15:0] scl, input logic signed [13:0] off,
                     input logic signed [13:0] ed, input logic eu, input int el);
    send(y, scl, off, ed, eu, el, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    int t;
    areset        = 1'b1;
    cfg_data      = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    fork
      forever begin
        @(negedge aclk);
        monitor_step();
      end
    join_none

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'sd0);
    chk("rst_tdata", $signed(m_axis_tdata), 32'sd0);
    chk("rst_tuser", {31'd0, m_axis_tuser}, 32'sd0);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'sd1);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Basic, offset/unity, sign combinations
    run( 14'sd1000,  16'd16384, 14'sd0,    14'sd2000, 1'b0, LAT);
    run(-14'sd1000,  16'd16384, 14'sd0,   -14'sd2000, 1'b0, LAT);
    run( 14'sd1100,  16'd32767, 14'sd100,  14'sd1000, 1'b0, LAT);
    run( 14'sd1000,  16'h8000,  14'sd0,   -14'sd1000, 1'b0, LAT);
    run(-14'sd1000,  16'hC000,  14'sd0,    14'sd2000, 1'b0, LAT);
    // Rounding
    run( 14'sd5,     16'd24576, 14'sd0,    R5,        1'b0, LAT);
    run( 14'sd1,     16'd24576, 14'sd0,    14'sd1,    1'b0, LAT);
    // Range edges: exact minimum is not a saturation, +2^13 is
    run(-14'sd4096,  16'd16384, 14'sd0,   -14'sd8192, 1'b0, LAT);
    run( 14'sd4096,  16'd16384, 14'sd0,    14'sd8191, 1'b1, LAT);
    // Saturation
    run( 14'sd1,     16'd1,     14'sd0,    14'sd8191, 1'b1, LAT);
    run( 14'sd1,     16'hFFFF,  14'sd0,   -14'sd8192, 1'b1, LAT);
    // Zero scale
    run( 14'sd5,     16'd0,     14'sd0,    14'sd8191, 1'b1, 1);
    run( 14'sd0,     16'd0,     14'sd0,    14'sd0,    1'b1, 1);
    run(-14'sd5,     16'd0,     14'sd0,   -14'sd8192, 1'b1, 1);

    // Backpressure: output held for 5 cycles
    m_axis_tready = 1'b0;
    send(14'sd300, 16'd16384, 14'sd0, 14'sd600, 1'b0, LAT, 1'b1, 1'b0);
    t = 0;
    @(negedge aclk);
    while (!m_axis_tvalid && t < 200) begin
      @(negedge aclk);
      t++;
    end
    repeat (5) begin
      chk("bp_tvalid", {31'd0, m_axis_tvalid}, 32'sd1);
      chk("bp_tdata", $signed(m_axis_tdata), 32'sd600);
      chk("bp_tuser", {31'd0, m_axis_tuser}, 32'sd0);
      chk("bp_s_tready", {31'd0, s_axis_tready}, 32'sd0);
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    drain();

    // cfg_data changes mid-divide must not affect the sample in flight
    send(14'sd110, 16'd16384, 14'sd10, 14'sd200, 1'b0, LAT, 1'b1, 1'b1);
    drain();

    // Reset mid-divide: pending result must be discarded
    send(14'sd50, 16'd16384, 14'sd0, 14'sd0, 1'b0, -1, 1'b0, 1'b0);
    repeat (9) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'sd0);
    chk("midrst_tdata", $signed(m_axis_tdata), 32'sd0);
    chk("midrst_tuser", {31'd0, m_axis_tuser}, 32'sd0);
    chk("midrst_s_tready", {31'd0, s_axis_tready}, 32'sd1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (40) @(posedge aclk);
    @(negedge aclk);
    chk("postrst_idle_tvalid", {31'd0, m_axis_tvalid}, 32'sd0);
    @(posedge aclk);
    #1;
    run(14'sd7, 16'd16384, 14'sd0, 14'sd14, 1'b0, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
